// File: rtl/seg_scan_if.sv
// Bus between a multiplexed 7-segment driver and the scan reader.
// The driver owns seg/dig_sel. The reader returns the decoded digits and the event pulses.
interface seg_scan_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic                    upd;
  logic [1:0]              upd_idx;
  logic                    err;

  modport master (
    output seg, dig_sel,
    input  value, digit_valid, upd, upd_idx, err
  );

  modport slave (
    input  seg, dig_sel,
    output value, digit_valid, upd, upd_idx, err
  );
endinterface

// File: rtl/seg_scan_reader.sv
// Loopback monitor for a multiplexed active-low 7-seg bus.
// It waits for each strobed pattern to settle, then decodes it back to a hex code per digit.
module seg_scan_reader #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 3
) (
  input logic         clk,
  input logic         resetn,
  seg_scan_if.slave   bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [6:0]       BLANK   = 7'h7F;

  typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [6:0]              held_seg;
  logic [NUM_DIGITS-1:0]   held_sel;
  logic [CNT_W-1:0]        cnt;
  logic                    match_c;
  logic                    onehot_c;
  logic                    commit_c;
  logic [4:0]              dec_c;
  logic [1:0]              idx_c;

  logic [4*NUM_DIGITS-1:0] value_reg;
  logic [NUM_DIGITS-1:0]   valid_reg;
  logic                    upd_reg;
  logic                    err_reg;
  logic [1:0]              idx_reg;

  // Returns {legal, code} for an active-low segment pattern.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h40:   decode = 5'h10;
      7'h79:   decode = 5'h11;
      7'h24:   decode = 5'h12;
      7'h30:   decode = 5'h13;
      7'h19:   decode = 5'h14;
      7'h12:   decode = 5'h15;
      7'h02:   decode = 5'h16;
      7'h78:   decode = 5'h17;
      7'h00:   decode = 5'h18;
      7'h10:   decode = 5'h19;
      7'h08:   decode = 5'h1A;
      7'h03:   decode = 5'h1B;
      7'h46:   decode = 5'h1C;
      7'h21:   decode = 5'h1D;
      7'h06:   decode = 5'h1E;
      7'h0E:   decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  assign match_c  = (bus.seg == held_seg) && (bus.dig_sel == held_sel);
  assign onehot_c = (bus.dig_sel != '0) &&
                    ((bus.dig_sel & (bus.dig_sel - NUM_DIGITS'(1))) == '0);
  assign dec_c    = decode(held_seg);

  always_comb begin
    idx_c = 2'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (held_sel[i]) idx_c = 2'(i);
    end
  end

  // Stability window: restart on any change, otherwise count matches up to the commit point.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      held_seg <= BLANK;
      held_sel <= '0;
      cnt      <= '0;
    end else if (!match_c) begin
      held_seg <= bus.seg;
      held_sel <= bus.dig_sel;
      cnt      <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // A change of input always takes priority over a commit in the same cycle.
  always_comb begin
    state_nxt = state;
    commit_c  = 1'b0;
    case (state)
      IDLE: begin
        if (onehot_c) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (!match_c) begin
          state_nxt = onehot_c ? SETTLE : IDLE;
        end else if (cnt == CNT_MAX) begin
          state_nxt = LOCKED;
          commit_c  = 1'b1;
        end
      end
      LOCKED: begin
        if (!match_c) state_nxt = onehot_c ? SETTLE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Commit only touches the strobed digit; illegal patterns flag err instead of upd.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      value_reg <= '0;
      valid_reg <= '0;
      upd_reg   <= 1'b0;
      err_reg   <= 1'b0;
      idx_reg   <= 2'd0;
    end else begin
      upd_reg <= 1'b0;
      err_reg <= 1'b0;
      if (commit_c) begin
        idx_reg <= idx_c;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (held_sel[i]) begin
            if (dec_c[4]) begin
              value_reg[4*i +: 4] <= dec_c[3:0];
              valid_reg[i]        <= 1'b1;
            end else begin
              valid_reg[i]        <= 1'b0;
            end
          end
        end
        if (dec_c[4] || held_seg == BLANK) upd_reg <= 1'b1;
        else                               err_reg <= 1'b1;
      end
    end
  end

  assign bus.value       = value_reg;
  assign bus.digit_valid = valid_reg;
  assign bus.upd         = upd_reg;
  assign bus.err         = err_reg;
  assign bus.upd_idx     = idx_reg;
endmodule
